// File: rtl/led_blink_multi.sv
// -----------------------------------------------------------------------------
// led_blink_multi
//
// Purpose:
//   Drives NUM_CH LED outputs. Each output blinks at one of four shared rates.
//   Four free-running rate counters produce a one-cycle tick at the end of each
//   half-period. Each channel toggles its LED on the tick of its selected rate.
//   A channel adopts a new rate selection only at the end of its current
//   half-period, so no half-period is ever cut short.
//
// Ports:
//   i_clock      sole clock; every register updates on its rising edge
//   i_rst_n      asynchronous active-low reset
//   i_enable     global run enable; when low, counters and LEDs clear
//   i_ch_en      per-channel enable mask, NUM_CH bits
//   i_rate_sel   per-channel rate select; bits [2c+1:2c] serve channel c
//   o_led_drive  registered LED drive, one bit per channel
//   o_rate_ack   one-cycle pulse when a channel adopts a changed rate
//
// Configuration:
//   LED_BLINK_MULTI_SYNC_EN  when defined, i_enable, i_ch_en and i_rate_sel
//                            pass through a two-flop synchroniser first. This
//                            adds exactly two cycles of input-to-effect latency.
// -----------------------------------------------------------------------------
module led_blink_multi #(
  parameter int NUM_CH    = 4,
  parameter int CNT_WIDTH = 16,
  parameter int P_RATE0   = 125,
  parameter int P_RATE1   = 250,
  parameter int P_RATE2   = 1250,
  parameter int P_RATE3   = 12500
) (
  input  logic                  i_clock,
  input  logic                  i_rst_n,
  input  logic                  i_enable,
  input  logic [NUM_CH-1:0]     i_ch_en,
  input  logic [2*NUM_CH-1:0]   i_rate_sel,
  output logic [NUM_CH-1:0]     o_led_drive,
  output logic [NUM_CH-1:0]     o_rate_ack
);

  function automatic int rateOf(input int r);
    case (r)
      0:       rateOf = P_RATE0;
      1:       rateOf = P_RATE1;
      2:       rateOf = P_RATE2;
      default: rateOf = P_RATE3;
    endcase
  endfunction

  // Terminal count of rate counter r (the half-period minus one).
  function automatic logic [CNT_WIDTH-1:0] lastCount(input int r);
    lastCount = CNT_WIDTH'(rateOf(r) - 1);
  endfunction

  // Reject parameter sets that cannot be represented.
  generate
    for (genvar r = 0; r < 4; r++) begin : g_rate_check
      if (rateOf(r) < 2 || longint'(rateOf(r)) > (longint'(1) << CNT_WIDTH)) begin : g_bad_rate
        $error("led_blink_multi: rate %0d half-period %0d outside 2..2^CNT_WIDTH", r, rateOf(r));
      end
    end
    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
      $error("led_blink_multi: NUM_CH %0d outside 1..16", NUM_CH);
    end
  endgenerate

  // Working copies of the control inputs, either raw or synchronised.
  logic                enW;
  logic [NUM_CH-1:0]   chEnW;
  logic [2*NUM_CH-1:0] rateSelW;

`ifdef LED_BLINK_MULTI_SYNC_EN
  logic                enSync1_q,      enSync2_q;
  logic [NUM_CH-1:0]   chEnSync1_q,    chEnSync2_q;
  logic [2*NUM_CH-1:0] rateSelSync1_q, rateSelSync2_q;

  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      enSync1_q      <= 1'b0;
      enSync2_q      <= 1'b0;
      chEnSync1_q    <= '0;
      chEnSync2_q    <= '0;
      rateSelSync1_q <= '0;
      rateSelSync2_q <= '0;
    end else begin
      enSync1_q      <= i_enable;
      enSync2_q      <= enSync1_q;
      chEnSync1_q    <= i_ch_en;
      chEnSync2_q    <= chEnSync1_q;
      rateSelSync1_q <= i_rate_sel;
      rateSelSync2_q <= rateSelSync1_q;
    end
  end

  assign enW      = enSync2_q;
  assign chEnW    = chEnSync2_q;
  assign rateSelW = rateSelSync2_q;
`else
  assign enW      = i_enable;
  assign chEnW    = i_ch_en;
  assign rateSelW = i_rate_sel;
`endif

  logic [CNT_WIDTH-1:0] cnt_q [4];
  logic [CNT_WIDTH-1:0] cnt_d [4];
  logic [1:0]           sel_q [NUM_CH];
  logic [1:0]           sel_d [NUM_CH];
  logic [1:0]           newSel [NUM_CH];
  logic [NUM_CH-1:0]    led_q, led_d;
  logic [NUM_CH-1:0]    ack_q, ack_d;
  logic [3:0]           tick;
  logic [NUM_CH-1:0]    tickSel;
  logic [NUM_CH-1:0]    loadSel;

  // The tick of a channel's current selection marks the end of its
  // half-period. A toggle on that edge uses the old selection, and the
  // new selection takes effect from the following edge. A disabled channel
  // has no half-period in progress, so it may load a new selection freely.
  always_comb begin
    tick    = '0;
    tickSel = '0;
    loadSel = '0;
    led_d   = '0;
    ack_d   = '0;
    for (int r = 0; r < 4; r++) begin
      tick[r]  = enW && (cnt_q[r] == lastCount(r));
      cnt_d[r] = (!enW || tick[r]) ? '0 : cnt_q[r] + CNT_WIDTH'(1);
    end
    for (int c = 0; c < NUM_CH; c++) begin
      newSel[c]  = rateSelW[2*c +: 2];
      tickSel[c] = tick[sel_q[c]];
      loadSel[c] = tickSel[c] || !chEnW[c] || !enW;
      sel_d[c]   = loadSel[c] ? newSel[c] : sel_q[c];
      led_d[c]   = (enW && chEnW[c]) ? (led_q[c] ^ tickSel[c]) : 1'b0;
      ack_d[c]   = enW && chEnW[c] && tickSel[c] && (newSel[c] != sel_q[c]);
    end
  end

  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '{default: '0};
      sel_q <= '{default: '0};
      led_q <= '0;
      ack_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      sel_q <= sel_d;
      led_q <= led_d;
      ack_q <= ack_d;
    end
  end

  assign o_led_drive = led_q;
  assign o_rate_ack  = ack_q;

endmodule

// File: doc/led_blink_multi.md
LED_BLINK_MULTI -- requirements
Module: led_blink_multi

Interface
- REQ-001: Parameter NUM_CH, default 4: number of independent LED channels (1..16).
- REQ-002: Parameter CNT_WIDTH, default 16: width of each rate counter.
- REQ-003: Parameters P_RATE0, P_RATE1, P_RATE2, P_RATE3, defaults 125, 250, 1250, 12500: half-period, in clocks, of rates 0..3 (100/50/10/1 Hz at 25 kHz).
- REQ-004: i_clock  input  1  sole clock; all state updates on its rising edge.
- REQ-005: i_rst_n  input  1  reset, asynchronous, active-low.
- REQ-006: i_enable  input  1  global run enable.
- REQ-007: i_ch_en  input  NUM_CH  per-channel enable mask.
- REQ-008: i_rate_sel  input  2*NUM_CH  per-channel rate select; bits [2c+1:2c] serve channel c.
- REQ-009: o_led_drive  output  NUM_CH  registered LED drive, one bit per channel.
- REQ-010: o_rate_ack  output  NUM_CH  one-cycle pulse when channel c adopts a changed rate select.

Function
- REQ-011: Four rate counters shall run with i_enable=1, each counting 0..P_RATEr-1 against its own P_RATEr, and wrapping to 0.
- REQ-012: tick[r] shall be asserted in the cycle in which counter r equals P_RATEr-1 and i_enable=1.
- REQ-013: With i_enable=0, all rate counters shall clear to 0, all o_led_drive bits shall clear to 0, and all o_rate_ack bits shall be 0 on the next edge.
- REQ-014: Each channel shall hold a registered selection sel_q[c]; o_led_drive[c] shall toggle on every edge where tick[sel_q[c]]=1 and i_ch_en[c]=1.
- REQ-015: sel_q[c] shall load i_rate_sel[c] only on an edge where tick[sel_q[c]]=1, or on any edge while i_ch_en[c]=0 or i_enable=0, so that no half-period is truncated.
- REQ-016: o_rate_ack[c] shall pulse high for one cycle after any edge on which sel_q[c] loads a value different from its previous value, while i_ch_en[c]=1 and i_enable=1.
- REQ-017: With i_ch_en[c]=0, o_led_drive[c] shall clear to 0 on the next edge; rate counters shall be unaffected.
- REQ-018: Latency: with counters at 0, o_led_drive[c] shall rise on the P_RATEr-th edge that samples i_enable=1 and i_ch_en[c]=1 (r = sel_q[c]), then toggle every P_RATEr edges.
- REQ-019: Simultaneous tick and selection change: the output toggle shall use the old selection and the new selection shall apply from the next edge.
- REQ-020: Any P_RATEr outside 2..2^CNT_WIDTH shall raise an elaboration-time error.

Reset
- REQ-021: While i_rst_n=0, asynchronously: counters=0, sel_q=0, o_led_drive=0, o_rate_ack=0, synchroniser flops=0.
- REQ-022: After deassertion of i_rst_n, counting shall begin on the first rising edge with i_enable=1. Reset asserted mid-period shall abandon the period with no residual state.

Configuration
- REQ-023: Macro LED_BLINK_MULTI_SYNC_EN, when defined, shall insert a two-flop synchroniser on i_enable, i_ch_en and i_rate_sel. This adds exactly 2 cycles of input-to-effect latency to REQ-013..018.
- REQ-024: When LED_BLINK_MULTI_SYNC_EN is undefined, the inputs shall be used directly, with no added latency.

Verification (parameters P_RATE0..3 = 2, 4, 6, 8; NUM_CH=4; macro undefined unless stated)
- REQ-025: Release reset; i_enable=1, i_ch_en=4'hF, all selections 0..3 -> ch0..3 rise at edges 2, 4, 6, 8 and toggle every 2, 4, 6, 8 edges.
- REQ-026: ch0 running at rate 3; switch i_rate_sel[1:0] to 0 at edge 3 -> ch0 holds until edge 8, o_rate_ack[0] pulses after edge 8, then toggles every 2 edges.
- REQ-027: Deassert i_enable at edge 5 -> all o_led_drive=0 after the next edge. Reassert -> ch0 rises 2 edges later.
- REQ-028: Assert i_rst_n=0 asynchronously between edges mid-period -> all outputs 0 immediately, without waiting for a clock edge. Release -> REQ-025 timing repeats.
- REQ-029: Clear i_ch_en[2] while other channels run -> o_led_drive[2]=0 next edge; other channel periods are unchanged.
- REQ-030: With LED_BLINK_MULTI_SYNC_EN defined, repeat REQ-025 -> every first rise is delayed by 2 further edges.
